// File: rtl/inst_word_serializer.sv
// inst_word_serializer: turns one decoded instruction per request into the 16-bit instruction word stream,
// appending the immediate word after LDM and tracking the last accepted word and a word count.
module inst_word_serializer #(
    parameter logic [4:0]  LDM_OPCODE = 5'b00111,
    parameter logic [15:0] NOP_WORD   = 16'hF800,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_opcode,
    input  logic [10:0]      req_operand,
    input  logic [15:0]      req_imm,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [15:0]      word,
    output logic             word_is_imm,
    output logic [15:0]      last_word,
    output logic [CNT_W-1:0] word_count
);
    localparam logic [1:0] IDLE = 2'd0, OPW = 2'd1, IMM = 2'd2;
    logic [1:0]  state;
    logic [4:0]  op;
    logic [15:0] imm;
    logic        word_fire, req_fire, held_ldm;
    always_comb begin
        word_valid = (state == OPW) | (state == IMM);
        word_fire  = word_valid & word_ready;
        held_ldm   = op == LDM_OPCODE;
        req_ready  = (state == IDLE) | (state == OPW & word_fire & ~held_ldm) | (state == IMM & word_fire);
        req_fire   = req_valid & req_ready;
    end
    // a new request can only fire once the held word leaves, so it takes priority over the drain path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op          <= 5'd0;
            imm         <= 16'd0;
            word        <= 16'd0;
            word_is_imm <= 1'b0;
            last_word   <= NOP_WORD;
            word_count  <= '0;
        end else begin
            if (req_fire) begin
                state       <= OPW;
                op          <= req_opcode;
                imm         <= req_imm;
                word        <= {req_opcode, req_operand};
                word_is_imm <= 1'b0;
            end else if (word_fire) begin
                state       <= (state == OPW & held_ldm) ? IMM : IDLE;
                word        <= (state == OPW & held_ldm) ? imm : word;
                word_is_imm <= state == OPW & held_ldm;
            end
            if (word_fire) begin
                last_word  <= word;
                word_count <= word_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_inst_word_serializer.sv
// tb_inst_word_serializer: randomized and directed checks of inst_word_serializer against a queue-based model
// of the outstanding instruction-stream words.
module tb_inst_word_serializer;
    localparam logic [4:0] LDM = 5'b00111;
    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid = 1'b0, word_ready = 1'b0;
    logic [4:0] req_opcode = 5'd0;
    logic [10:0] req_operand = 11'd0;
    logic [15:0] req_imm = 16'd0;
    logic req_ready, word_valid, word_is_imm;
    logic [15:0] word, last_word, word_count;
    logic req_ready4, word_valid4, word_is_imm4;
    logic [15:0] word4, last_word4;
    logic [3:0] word_count4;
    int n_tests = 0, n_fail = 0;
    logic [16:0] q[$];
    logic [15:0] m_last;
    int m_cnt;
    logic acc;

    always #5 clk = ~clk;

    inst_word_serializer dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_operand(req_operand), .req_imm(req_imm),
        .word_valid(word_valid), .word_ready(word_ready), .word(word),
        .word_is_imm(word_is_imm), .last_word(last_word), .word_count(word_count)
    );

    inst_word_serializer #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready4),
        .req_opcode(req_opcode), .req_operand(req_operand), .req_imm(req_imm),
        .word_valid(word_valid4), .word_ready(word_ready), .word(word4),
        .word_is_imm(word_is_imm4), .last_word(last_word4), .word_count(word_count4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_reset();
        check("rst word_valid", {31'd0, word_valid}, 32'd0);
        check("rst req_ready", {31'd0, req_ready}, 32'd1);
        check("rst last_word", {16'd0, last_word}, 32'h0000F800);
        check("rst word_count", {16'd0, word_count}, 32'd0);
        check("rst word_count4", {28'd0, word_count4}, 32'd0);
        check("rst word_valid4", {31'd0, word_valid4}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        word_ready = 1'b0;
        q.delete();
        m_last = 16'hF800;
        m_cnt = 0;
        #1;
        check_idle_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // called at a falling edge; the model advances at the following rising edge
    task automatic step(input logic v, input logic [4:0] o, input logic [10:0] opr,
                        input logic [15:0] im, input logic wr, output logic accepted);
        logic er, wf, rf;
        req_valid = v; req_opcode = o; req_operand = opr; req_imm = im; word_ready = wr;
        #1;
        er = (q.size() == 0) || (q.size() == 1 && wr);
        check("req_ready", {31'd0, req_ready}, {31'd0, er});
        check("req_ready4", {31'd0, req_ready4}, {31'd0, er});
        check("word_valid", {31'd0, word_valid}, {31'd0, q.size() > 0});
        if (q.size() > 0) begin
            check("word", {16'd0, word}, {16'd0, q[0][15:0]});
            check("word_is_imm", {31'd0, word_is_imm}, {31'd0, q[0][16]});
            check("word4", {16'd0, word4}, {16'd0, q[0][15:0]});
        end
        check("last_word", {16'd0, last_word}, {16'd0, m_last});
        check("word_count", {16'd0, word_count}, 32'(m_cnt % 65536));
        check("word_count4", {28'd0, word_count4}, 32'(m_cnt % 16));
        wf = (q.size() > 0) && wr;
        rf = v && er;
        @(posedge clk);
        if (wf) begin
            m_last = q[0][15:0];
            void'(q.pop_front());
            m_cnt++;
        end
        if (rf) begin
            q.push_back({1'b0, o, opr});
            if (o == LDM) q.push_back({1'b1, im});
        end
        accepted = rf;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 11'd0, 16'd0, 1'b1, acc);
    endtask

    initial begin
        logic [4:0] op3[4];
        logic [4:0] ro;
        logic [10:0] rp;
        logic [15:0] ri;
        m_last = 16'hF800;
        m_cnt = 0;
        @(negedge clk);
        do_reset();
        // single-word ADD
        step(1'b1, 5'd0, 11'h012, 16'h0, 1'b1, acc);
        check("t1 accepted", {31'd0, acc}, 32'd1);
        check("t1 word", {16'd0, word}, 32'h0012);
        step(1'b0, 5'd0, 11'd0, 16'd0, 1'b1, acc);
        check("t1 last_word", {16'd0, last_word}, 32'h0012);
        check("t1 count", {16'd0, word_count}, 32'd1);
        check("t1 idle", {31'd0, word_valid}, 32'd0);
        // LDM with immediate
        step(1'b1, LDM, 11'h001, 16'hF0F0, 1'b1, acc);
        check("t2 opword", {16'd0, word}, 32'h3801);
        step(1'b0, 5'd0, 11'd0, 16'd0, 1'b1, acc);
        check("t2 imm", {16'd0, word}, 32'hF0F0);
        check("t2 is_imm", {31'd0, word_is_imm}, 32'd1);
        drain();
        // back-to-back stream INC, DEC, LDM(3800), NOP
        do_reset();
        op3[0] = 5'b00010; op3[1] = 5'b10000; op3[2] = LDM; op3[3] = 5'b11111;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, op3[i], 11'd0, 16'h3800, 1'b1, acc);
            if (i == 3) check("t3 nop waits", {31'd0, acc}, 32'd0);
            else check("t3 accepted", {31'd0, acc}, 32'd1);
        end
        step(1'b1, op3[3], 11'd0, 16'h0, 1'b1, acc);
        check("t3 nop accepted", {31'd0, acc}, 32'd1);
        step(1'b0, 5'd0, 11'd0, 16'd0, 1'b1, acc);
        check("t3 count", {16'd0, word_count}, 32'd5);
        check("t3 last", {16'd0, last_word}, 32'hF800);
        // reset while the immediate is pending
        do_reset();
        step(1'b1, LDM, 11'h055, 16'hBEEF, 1'b1, acc);
        step(1'b0, 5'd0, 11'd0, 16'd0, 1'b1, acc);
        check("t5 in imm", {31'd0, word_is_imm}, 32'd1);
        #2;
        rst_n = 1'b0;
        q.delete();
        m_last = 16'hF800;
        m_cnt = 0;
        #1;
        check_idle_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 5'd3, 11'h123, 16'h0, 1'b1, acc);
        check("t5 after reset", {16'd0, word}, {16'd0, 5'd3, 11'h123});
        drain();
        // 17 words to wrap the 4-bit counter
        do_reset();
        for (int i = 0; i < 17; i++) step(1'b1, 5'd1, 11'(i), 16'h0, 1'b1, acc);
        drain();
        check("t6 count4", {28'd0, word_count4}, 32'd1);
        check("t6 count16", {16'd0, word_count}, 32'd17);
        // random traffic with stalls, LDM heavy
        do_reset();
        ro = 5'($urandom_range(0, 31)); rp = 11'($urandom); ri = 16'($urandom);
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 7, ro, rp, ri, $urandom_range(0, 9) < 6, acc);
            if (acc) begin
                ro = ($urandom_range(0, 9) < 4) ? LDM : 5'($urandom_range(0, 31));
                rp = 11'($urandom);
                ri = ($urandom_range(0, 7) == 0) ? 16'h3800 : 16'($urandom);
            end
        end
        drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
